mac_seq_ctrl: RTL and testbench
===============================

# mac_seq_ctrl

Sequencer for a row of `NUM_MAC` int4 MAC units computing dot products of programmable depth. On a start command it clears the accumulators and streams `k_len` weight/activation address pairs to the synchronous operand buffers. It gates the MAC enable in step with returning buffer data, drains the MAC pipeline, then presents the accumulated results to the downstream writer with a valid/ready handshake. The block sits between the layer scheduler (start/done) and the MAC row plus its weight and activation SRAMs.

## Interface
- `NUM_MAC`, default 8: number of MAC units driven in lockstep; only used for the `mac_en` and `mac_clr` fan-out width.
- `ADDR_W`, default 10: operand buffer address width.
- `K_W`, default 10: width of `k_len`.
- `MAC_LAT`, default 2: MAC pipeline depth, in cycles, from an operand capture to the accumulator update.
- `clk`, in, 1: clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: start request; sampled only in IDLE.
- `k_len`, in, K_W: dot-product depth; latched on start.
- `w_base`, in, ADDR_W: weight buffer start address; latched on start.
- `a_base`, in, ADDR_W: activation buffer start address; latched on start.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse on the result handshake.
- `rd_en`, out, 1: read strobe to both buffers; data returns 1 cycle later.
- `w_addr`, out, ADDR_W: weight read address.
- `a_addr`, out, ADDR_W: activation read address.
- `mac_clr`, out, NUM_MAC: synchronous clear to the MACs (their reset input).
- `mac_en`, out, NUM_MAC: MAC enable, all bits identical.
- `op_zero`, out, 1: forces the operand mux in front of the MACs to 0.
- `res_valid`, out, 1: MAC outputs are stable and valid.
- `res_ready`, in, 1: downstream accepts the results.

## Operation
- **States:** IDLE, CLEAR, FETCH, DRAIN, OUT. Encoding is free.
- **IDLE:**
  - On `start`=1: latch `k_len`, `w_base` and `a_base`, then go to CLEAR.
  - In any other state, `start` is ignored. A start is never queued.
- **CLEAR:** held for 1 cycle with `mac_clr`=all ones.
  - Next state is FETCH if the latched k is nonzero.
  - If k=0, go directly to OUT. The cleared result is valid as 0.
- **FETCH:** held for exactly k cycles with `rd_en`=1.
  - The read index i runs 0..k-1.
  - `w_addr`=`w_base`+i and `a_addr`=`a_base`+i, modulo 2^ADDR_W. Address wrap-around is legal and silent.
  - After the last read, go to DRAIN.
- **DRAIN:** held for MAC_LAT+1 cycles.
  - In the first cycle the last buffer data is live.
  - In the remaining MAC_LAT cycles `op_zero`=1, which flushes the pipeline with zero products.
  - Then go to OUT.
- **mac_en:**
  - Equals `rd_en` delayed by 1 cycle, OR'd with state==DRAIN.
  - Low in IDLE, CLEAR and OUT, so the MAC outputs hold.
- **OUT:**
  - `res_valid`=1 until the cycle in which `res_ready`=1.
  - On that cycle `done`=1, and the next state is IDLE.
  - `res_valid` stays asserted regardless of `res_ready` until the handshake completes (no retraction).
- **k_len:** a maximum value of 2^K_W−1 is legal. The internal counter is K_W bits wide and compares against k−1, so it does not overflow.

## Timing
- **Reset values** (asserted asynchronously, regardless of clk):
  - State is IDLE.
  - `busy`, `done`, `rd_en`, `mac_en`, `mac_clr`, `op_zero` and `res_valid` are all 0.
  - `w_addr` and `a_addr` are 0.
- **Reset deassertion:** release is synchronised internally. The first `start` is honoured on the second rising edge after release.
- **Reset mid-operation:** all outputs return to their reset values immediately. No `done` is produced, and the MAC contents are don't-care until the next CLEAR.
- **Cycle map**, with the start-accept edge as cycle 0 and k≥1:
  - CLEAR at cycle 1.
  - `rd_en` on cycles 2..k+1.
  - `mac_en` on cycles 3..k+2+MAC_LAT.
  - `op_zero` on cycles k+3..k+2+MAC_LAT.
  - `res_valid` from cycle k+3+MAC_LAT.
- **Latency** from start to the earliest `done` is k+MAC_LAT+3 cycles. For k=0 it is 2 cycles: CLEAR at cycle 1, OUT at cycle 2.
- **Back-to-back:** a start in the cycle after `done` (state IDLE) is accepted. Throughput is one job per k+MAC_LAT+4 cycles.
- **Outputs:** all are registered or decoded from registered state only. None depends combinationally on `start` or `res_ready`, except `done`, which is state==OUT AND `res_ready`.

## Test plan
- **Basic dot product:** reset, then start with k=3, bases 0/0. Weights are 7,7,7 and activations are −8,−8,−8, with MAC_LAT=2 and real MAC instances.
  - `rd_en` on cycles 2–4 with addresses 0,1,2.
  - `res_valid` at cycle 8.
  - Every MAC out = −168.
  - `done` on the first `res_ready`.
- **k=0:** start with k=0.
  - `mac_clr` at cycle 1.
  - `res_valid` at cycle 2, with the MAC outputs at 0.
  - `rd_en` and `mac_en` are never asserted.
- **Address wrap and backpressure:** start with k=4, `w_base`=1022, ADDR_W=10, and `res_ready` held low for 5 cycles.
  - `w_addr` sequence is 1022,1023,0,1.
  - `res_valid` stays high and the MAC outputs stay constant while stalled.
  - `done` is exactly one pulse.
- **Start ignored while busy:** pulse `start` during FETCH and again during OUT, with `k_len` changed.
  - The running job's count and addresses are unchanged.
  - No second job starts without a new start in IDLE.
- **Reset mid-FETCH:** assert `reset` low at cycle 4 of a k=8 job.
  - All outputs go to 0 immediately.
  - After release, a new k=2 job completes with the correct sum, unaffected by the stale accumulators.
- **Back-to-back jobs:** run k=5 then k=1 with the second start in the cycle after `done`.
  - The second `mac_clr` occurs exactly 1 cycle after acceptance.
  - The results match the reference sums independently.

Source files
------------

// File: rtl/mac_seq_ctrl.sv
// Sequencer for a row of int4 MAC units: clears the accumulators, streams k operand
// address pairs to the synchronous buffers, drains the MAC pipeline, then hands off results.
module mac_seq_ctrl #(
    parameter int NUM_MAC = 8,
    parameter int ADDR_W  = 10,
    parameter int K_W     = 10,
    parameter int MAC_LAT = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [K_W-1:0]     k_len,
    input  logic [ADDR_W-1:0]  w_base,
    input  logic [ADDR_W-1:0]  a_base,
    output logic               busy,
    output logic               done,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  w_addr,
    output logic [ADDR_W-1:0]  a_addr,
    output logic [NUM_MAC-1:0] mac_clr,
    output logic [NUM_MAC-1:0] mac_en,
    output logic               op_zero,
    output logic               res_valid,
    input  logic               res_ready
);

    localparam int DW = $clog2(MAC_LAT + 1) + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic              r_rst_q;
    logic [K_W-1:0]    r_k;
    logic [K_W-1:0]    r_cnt;
    logic [DW-1:0]     r_drain_cnt;
    logic [ADDR_W-1:0] r_w_addr;
    logic [ADDR_W-1:0] r_a_addr;
    logic              r_rd_q;
    logic              w_start_acc;

    // Starts are only honoured once the released reset has been seen by one clock edge.
    assign w_start_acc = start && r_rst_q;

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start_acc) w_state_nxt = S_CLEAR;
            S_CLEAR: w_state_nxt = (r_k == '0) ? S_OUT : S_FETCH;
            S_FETCH: if (r_cnt == r_k - K_W'(1)) w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_drain_cnt == DW'(MAC_LAT)) w_state_nxt = S_OUT;
            S_OUT:   if (res_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, with an asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_rst_q     <= 1'b0;
            r_k         <= '0;
            r_cnt       <= '0;
            r_drain_cnt <= '0;
            r_w_addr    <= '0;
            r_a_addr    <= '0;
            r_rd_q      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rst_q <= 1'b1;
            r_rd_q  <= (r_state == S_FETCH);
            case (r_state)
                S_IDLE: begin
                    if (w_start_acc) begin
                        r_k      <= k_len;
                        r_w_addr <= w_base;
                        r_a_addr <= a_base;
                    end
                end
                S_CLEAR: begin
                    r_cnt       <= '0;
                    r_drain_cnt <= '0;
                end
                S_FETCH: begin
                    // Address wrap past 2^ADDR_W-1 is intentional.
                    r_cnt    <= r_cnt + K_W'(1);
                    r_w_addr <= r_w_addr + ADDR_W'(1);
                    r_a_addr <= r_a_addr + ADDR_W'(1);
                end
                S_DRAIN: r_drain_cnt <= r_drain_cnt + DW'(1);
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign rd_en     = (r_state == S_FETCH);
    assign w_addr    = r_w_addr;
    assign a_addr    = r_a_addr;
    assign mac_clr   = {NUM_MAC{r_state == S_CLEAR}};
    // MAC enable follows buffer data, which lags the read strobe by one cycle.
    assign mac_en    = {NUM_MAC{r_rd_q || (r_state == S_DRAIN)}};
    assign op_zero   = (r_state == S_DRAIN) && (r_drain_cnt != '0);
    assign res_valid = (r_state == S_OUT);
    assign done      = (r_state == S_OUT) && res_ready;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with behavioural operand buffers and int4 MAC row.
module tb_mac_seq_ctrl;

    localparam int NUM_MAC = 8;
    localparam int ADDR_W  = 10;
    localparam int K_W     = 10;
    localparam int MAC_LAT = 2;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic               res_ready = 1'b0;
    logic [K_W-1:0]     k_len = '0;
    logic [ADDR_W-1:0]  w_base = '0;
    logic [ADDR_W-1:0]  a_base = '0;
    logic               busy, done, rd_en, op_zero, res_valid;
    logic [ADDR_W-1:0]  w_addr, a_addr;
    logic [NUM_MAC-1:0] mac_clr, mac_en;

    int n_checks = 0;
    int n_errors = 0;

    mac_seq_ctrl #(
        .NUM_MAC(NUM_MAC), .ADDR_W(ADDR_W), .K_W(K_W), .MAC_LAT(MAC_LAT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .k_len(k_len),
        .w_base(w_base), .a_base(a_base), .busy(busy), .done(done),
        .rd_en(rd_en), .w_addr(w_addr), .a_addr(a_addr),
        .mac_clr(mac_clr), .mac_en(mac_en), .op_zero(op_zero),
        .res_valid(res_valid), .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    // Synchronous operand buffers and a MAC_LAT=2 MAC row (product stage, carry stage, accumulate).
    logic signed [3:0] wmem [1024];
    logic signed [3:0] amem [1024];
    logic signed [3:0] w_q, a_q, op_w, op_a;
    int p0 [NUM_MAC];
    int p1 [NUM_MAC];
    int acc [NUM_MAC];

    always @(posedge clk) if (rd_en) begin
        w_q <= wmem[w_addr];
        a_q <= amem[a_addr];
    end

    assign op_w = op_zero ? 4'sd0 : w_q;
    assign op_a = op_zero ? 4'sd0 : a_q;

    always @(posedge clk) begin
        for (int i = 0; i < NUM_MAC; i++) begin
            if (mac_clr[i]) begin
                p0[i]  <= 0;
                p1[i]  <= 0;
                acc[i] <= 0;
            end else if (mac_en[i]) begin
                p0[i]  <= int'(op_w) * int'(op_a);
                p1[i]  <= p0[i];
                acc[i] <= acc[i] + p1[i];
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Runs one job and checks every control output against the cycle map each cycle.
    task automatic exercise_job(input int k, input int wb, input int ab, input int stall,
                                input int ign1, input int ign2, input int exp_sum,
                                input bit chain, input string name);
        int out_start, d, last, bad;
        bit e_clr, e_rd, e_men, e_oz, e_val, e_done, e_busy;
        logic [2*NUM_MAC+4:0] obs, exp_v;
        logic [ADDR_W-1:0] exp_w, exp_a;
        out_start = (k > 0) ? k + 3 + MAC_LAT : 2;
        d = out_start + stall;
        last = chain ? d : d + 3;
        @(negedge clk);
        start = 1'b1;
        k_len = K_W'(k);
        w_base = ADDR_W'(wb);
        a_base = ADDR_W'(ab);
        res_ready = 1'b0;
        @(posedge clk);
        for (int n = 1; n <= last; n++) begin
            @(negedge clk);
            start = (n == ign1) || (n == ign2);
            if (start) begin
                k_len  = K_W'(k + 7);
                w_base = w_base + ADDR_W'(5);
                a_base = a_base + ADDR_W'(9);
            end
            res_ready = (n >= d);
            #1;
            e_clr  = (n == 1);
            e_rd   = (k > 0) && (n >= 2) && (n <= k + 1);
            e_men  = (k > 0) && (n >= 3) && (n <= k + 2 + MAC_LAT);
            e_oz   = (k > 0) && (n >= k + 3) && (n <= k + 2 + MAC_LAT);
            e_val  = (n >= out_start) && (n <= d);
            e_done = (n == d);
            e_busy = (n <= d);
            exp_v = {e_busy, e_done, e_rd, e_oz, e_val, {NUM_MAC{e_men}}, {NUM_MAC{e_clr}}};
            obs   = {busy, done, rd_en, op_zero, res_valid, mac_en, mac_clr};
            n_checks++;
            if (obs !== exp_v) begin
                n_errors++;
                $display("FAIL %s ctrl cycle %0d: got %b expected %b", name, n, obs, exp_v);
            end
            if (e_rd) begin
                exp_w = ADDR_W'(wb + n - 2);
                exp_a = ADDR_W'(ab + n - 2);
                n_checks++;
                if (w_addr !== exp_w || a_addr !== exp_a) begin
                    n_errors++;
                    $display("FAIL %s addr cycle %0d: got w=%0d a=%0d expected w=%0d a=%0d",
                             name, n, w_addr, a_addr, exp_w, exp_a);
                end
            end
            if (e_val) begin
                bad = -1;
                for (int i = 0; i < NUM_MAC; i++) if (acc[i] != exp_sum) bad = i;
                n_checks++;
                if (bad >= 0) begin
                    n_errors++;
                    $display("FAIL %s result cycle %0d: mac%0d got %0d expected %0d",
                             name, n, bad, acc[bad], exp_sum);
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [2*NUM_MAC+4:0] obs;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        obs = {busy, done, rd_en, op_zero, res_valid, mac_en, mac_clr};
        n_checks++;
        if (obs !== '0 || w_addr !== '0 || a_addr !== '0) begin
            n_errors++;
            $display("FAIL reset_values: got %b w=%0d a=%0d expected all 0", obs, w_addr, a_addr);
        end
        // Release with start already high: first edge ignores it, second edge accepts it.
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        k_len = '0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release_edge1: got busy=%b expected 0", busy);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1 || mac_clr !== '1) begin
            n_errors++;
            $display("FAIL reset_release_edge2: got busy=%b mac_clr=%b expected 1/all ones", busy, mac_clr);
        end
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release_job_end: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 3; i++) begin
            wmem[i] = 4'sd7;
            amem[i] = -4'sd8;
        end
        exercise_job(3, 0, 0, 0, 0, 0, -168, 1'b0, "basic");
    endtask

    task automatic test_k_zero();
        exercise_job(0, 50, 60, 1, 0, 0, 0, 1'b0, "k_zero");
    endtask

    task automatic test_wrap_backpressure();
        wmem[1022] = 4'sd1;  wmem[1023] = 4'sd2;  wmem[0] = 4'sd3;  wmem[1] = -4'sd4;
        amem[10]   = 4'sd5;  amem[11]   = -4'sd6; amem[12] = 4'sd7; amem[13] = 4'sd1;
        exercise_job(4, 1022, 10, 5, 0, 0, 10, 1'b0, "wrap_stall");
    endtask

    task automatic test_start_ignored();
        wmem[100] = 4'sd2; wmem[101] = 4'sd3;  wmem[102] = 4'sd4;
        amem[200] = 4'sd1; amem[201] = -4'sd1; amem[202] = 4'sd2;
        // FETCH spans cycles 2..4, OUT spans 8..11 with a 3-cycle stall.
        exercise_job(3, 100, 200, 3, 3, 9, 7, 1'b0, "start_ignored");
    endtask

    task automatic test_reset_mid_fetch();
        logic [2*NUM_MAC+4:0] obs;
        for (int i = 0; i < 8; i++) begin
            wmem[300 + i] = 4'sd7;
            amem[300 + i] = 4'sd7;
        end
        wmem[400] = -4'sd8; wmem[401] = -4'sd8;
        amem[500] = -4'sd8; amem[501] = 4'sd3;
        @(negedge clk);
        start = 1'b1;
        k_len = K_W'(8);
        w_base = ADDR_W'(300);
        a_base = ADDR_W'(300);
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (rd_en !== 1'b1 || w_addr !== ADDR_W'(302)) begin
            n_errors++;
            $display("FAIL mid_fetch_pre: got rd_en=%b w=%0d expected 1/302", rd_en, w_addr);
        end
        #2;
        reset = 1'b0;
        #1;
        obs = {busy, done, rd_en, op_zero, res_valid, mac_en, mac_clr};
        n_checks++;
        if (obs !== '0 || w_addr !== '0 || a_addr !== '0) begin
            n_errors++;
            $display("FAIL mid_fetch_async_reset: got %b w=%0d a=%0d expected all 0", obs, w_addr, a_addr);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        exercise_job(2, 400, 500, 0, 0, 0, 40, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) begin
            wmem[600 + i] = 4'(i + 1);
            amem[700 + i] = -4'sd1;
        end
        wmem[610] = -4'sd7;
        amem[710] = -4'sd7;
        exercise_job(5, 600, 700, 0, 0, 0, -15, 1'b1, "b2b_first");
        exercise_job(1, 610, 710, 0, 0, 0, 49, 1'b0, "b2b_second");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_k_zero();
        test_wrap_backpressure();
        test_start_ignored();
        test_reset_mid_fetch();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
